// File: rtl/network_interface.sv
// Local-port network interface: packetises PE requests towards router input 0 and buffers router output 0 for the PE.
// Define NETWORK_INTERFACE_STATS_EN to add 32-bit injection/ejection packet counters.
`ifndef X_NODES
`define X_NODES 3
`endif
`ifndef Y_NODES
`define Y_NODES 5
`endif

package network_interface_pkg;
    localparam int X_W    = (`X_NODES > 1) ? $clog2(`X_NODES) : 1;
    localparam int Y_W    = (`Y_NODES > 1) ? $clog2(`Y_NODES) : 1;
    localparam int DATA_W = 16;

    typedef struct packed {
        logic [X_W-1:0]    x_dest;
        logic [Y_W-1:0]    y_dest;
        logic [X_W-1:0]    x_source;
        logic [Y_W-1:0]    y_source;
        logic [DATA_W-1:0] data;
    } packet_t;
endpackage

// Circular-buffer FIFO; head reads as zero while empty so idle outputs stay clean.
module network_interface_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   count_reg;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == (PTR_W+1)'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = empty ? '0 : mem[rd_ptr_reg];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Storage is not reset; the empty gate on head hides stale entries.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg] <= push_data;
    end
endmodule

module network_interface
    import network_interface_pkg::*;
#(
    parameter int X_LOC     = 0,
    parameter int Y_LOC     = 0,
    parameter int INJ_DEPTH = 4,
    parameter int EJ_DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_pe_req_val,
    input  logic [X_W-1:0]    i_pe_x_dest,
    input  logic [Y_W-1:0]    i_pe_y_dest,
    input  logic [DATA_W-1:0] i_pe_data,
    output logic              o_pe_req_rdy,
    output packet_t           o_net_data,
    output logic              o_net_data_val,
    input  logic              i_net_en,
    input  packet_t           i_net_data,
    input  logic              i_net_data_val,
    output logic              o_net_en,
    output packet_t           o_pe_resp,
    output logic              o_pe_resp_val,
    input  logic              i_pe_resp_rdy,
    output logic              o_err_bad_dest,
    output logic              o_err_misroute
`ifdef NETWORK_INTERFACE_STATS_EN
    ,
    output logic [31:0]       o_inj_count,
    output logic [31:0]       o_ej_count
`endif
);
    packet_t req_pkt;
    logic    dest_ok;
    logic    req_accept;
    logic    inj_push;
    logic    inj_pop;
    logic    inj_empty;
    logic    inj_full;
    logic    ej_push;
    logic    ej_pop;
    logic    ej_empty;
    logic    ej_full;
    logic    misrouted;
    logic    err_bad_dest_reg;
    logic    err_misroute_reg;

    assign dest_ok = (32'(i_pe_x_dest) < 32'(`X_NODES)) && (32'(i_pe_y_dest) < 32'(`Y_NODES));

    always_comb begin
        req_pkt          = '0;
        req_pkt.x_dest   = i_pe_x_dest;
        req_pkt.y_dest   = i_pe_y_dest;
        req_pkt.x_source = X_W'(X_LOC);
        req_pkt.y_source = Y_W'(Y_LOC);
        req_pkt.data     = i_pe_data;
    end

    // Ready and enable depend only on registered occupancy, never on a same-cycle pop.
    assign o_pe_req_rdy   = !inj_full;
    assign req_accept     = i_pe_req_val && !inj_full;
    assign inj_push       = req_accept && dest_ok;
    assign o_net_data_val = !inj_empty;
    assign inj_pop        = o_net_data_val && i_net_en;

    assign o_net_en      = !ej_full;
    assign ej_push       = i_net_data_val && o_net_en;
    assign o_pe_resp_val = !ej_empty;
    assign ej_pop        = o_pe_resp_val && i_pe_resp_rdy;
    assign misrouted     = (i_net_data.x_dest != X_W'(X_LOC)) || (i_net_data.y_dest != Y_W'(Y_LOC));

    network_interface_fifo #(
        .DEPTH (INJ_DEPTH),
        .WIDTH ($bits(packet_t))
    ) u_inj_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (inj_push),
        .push_data (req_pkt),
        .pop       (inj_pop),
        .head      (o_net_data),
        .empty     (inj_empty),
        .full      (inj_full)
    );

    network_interface_fifo #(
        .DEPTH (EJ_DEPTH),
        .WIDTH ($bits(packet_t))
    ) u_ej_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (ej_push),
        .push_data (i_net_data),
        .pop       (ej_pop),
        .head      (o_pe_resp),
        .empty     (ej_empty),
        .full      (ej_full)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_bad_dest_reg <= 1'b0;
            err_misroute_reg <= 1'b0;
        end else begin
            if (req_accept && !dest_ok) err_bad_dest_reg <= 1'b1;
            if (ej_push && misrouted)   err_misroute_reg <= 1'b1;
        end
    end

    assign o_err_bad_dest = err_bad_dest_reg;
    assign o_err_misroute = err_misroute_reg;

`ifdef NETWORK_INTERFACE_STATS_EN
    logic [31:0] inj_count_reg;
    logic [31:0] ej_count_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            inj_count_reg <= '0;
            ej_count_reg  <= '0;
        end else begin
            if (inj_pop) inj_count_reg <= inj_count_reg + 32'd1;
            if (ej_push) ej_count_reg  <= ej_count_reg + 32'd1;
        end
    end

    assign o_inj_count = inj_count_reg;
    assign o_ej_count  = ej_count_reg;
`endif

    // The router must honour o_net_en; a packet offered while full is lost.
    a_no_drop: assert property (@(posedge clk) disable iff (!reset_n) i_net_data_val |-> o_net_en);
endmodule

// File: tb/tb_network_interface.sv
// Scoreboard bench for network_interface: directed scenarios plus random traffic against a queue-based model.
`ifndef X_NODES
`define X_NODES 3
`endif
`ifndef Y_NODES
`define Y_NODES 5
`endif

module tb_network_interface;
    import network_interface_pkg::*;

    localparam int XL = 1;
    localparam int YL = 1;
    localparam int ID = 4;
    localparam int ED = 4;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              i_pe_req_val;
    logic [X_W-1:0]    i_pe_x_dest;
    logic [Y_W-1:0]    i_pe_y_dest;
    logic [DATA_W-1:0] i_pe_data;
    logic              o_pe_req_rdy;
    packet_t           o_net_data;
    logic              o_net_data_val;
    logic              i_net_en;
    packet_t           i_net_data;
    logic              i_net_data_val;
    logic              o_net_en;
    packet_t           o_pe_resp;
    logic              o_pe_resp_val;
    logic              i_pe_resp_rdy;
    logic              o_err_bad_dest;
    logic              o_err_misroute;
`ifdef NETWORK_INTERFACE_STATS_EN
    logic [31:0]       o_inj_count;
    logic [31:0]       o_ej_count;
`endif

    network_interface #(
        .X_LOC     (XL),
        .Y_LOC     (YL),
        .INJ_DEPTH (ID),
        .EJ_DEPTH  (ED)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .i_pe_req_val   (i_pe_req_val),
        .i_pe_x_dest    (i_pe_x_dest),
        .i_pe_y_dest    (i_pe_y_dest),
        .i_pe_data      (i_pe_data),
        .o_pe_req_rdy   (o_pe_req_rdy),
        .o_net_data     (o_net_data),
        .o_net_data_val (o_net_data_val),
        .i_net_en       (i_net_en),
        .i_net_data     (i_net_data),
        .i_net_data_val (i_net_data_val),
        .o_net_en       (o_net_en),
        .o_pe_resp      (o_pe_resp),
        .o_pe_resp_val  (o_pe_resp_val),
        .i_pe_resp_rdy  (i_pe_resp_rdy),
        .o_err_bad_dest (o_err_bad_dest),
        .o_err_misroute (o_err_misroute)
`ifdef NETWORK_INTERFACE_STATS_EN
        ,
        .o_inj_count    (o_inj_count),
        .o_ej_count     (o_ej_count)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference model: packets accepted but not yet consumed, in order.
    packet_t     inj_q[$];
    packet_t     ej_q[$];
    logic        bad_exp = 1'b0;
    logic        mis_exp = 1'b0;
    logic [31:0] inj_cnt_exp = '0;
    logic [31:0] ej_cnt_exp = '0;
    packet_t     mon_pkt;
    packet_t     req_model;

    function automatic packet_t make_pkt(input int x, input int y, input int sx, input int sy, input int d);
        packet_t p;
        p.x_dest   = X_W'(x);
        p.y_dest   = Y_W'(y);
        p.x_source = X_W'(sx);
        p.y_source = Y_W'(sy);
        p.data     = DATA_W'(d);
        return p;
    endfunction

    // Monitor: compares the DUT against the model once per cycle, then advances the model
    // with the handshakes that the coming rising edge will complete.
    always @(negedge clk) begin
        if (reset_n) begin
            int  inj_n;
            int  ej_n;
            inj_n = inj_q.size();
            ej_n  = ej_q.size();
            check("req_rdy",  o_pe_req_rdy,   inj_n < ID);
            check("net_val",  o_net_data_val, inj_n != 0);
            check("net_en",   o_net_en,       ej_n < ED);
            check("resp_val", o_pe_resp_val,  ej_n != 0);
            check("err_bad_dest", o_err_bad_dest, bad_exp);
            check("err_misroute", o_err_misroute, mis_exp);
`ifdef NETWORK_INTERFACE_STATS_EN
            check("inj_count", o_inj_count, inj_cnt_exp);
            check("ej_count",  o_ej_count,  ej_cnt_exp);
`endif
            if (inj_n != 0 && i_net_en) begin
                mon_pkt = inj_q.pop_front();
                check("inj_pkt", 64'(o_net_data), 64'(mon_pkt));
                $display("inject  dest(%0d,%0d) src(%0d,%0d) data %h", o_net_data.x_dest, o_net_data.y_dest,
                         o_net_data.x_source, o_net_data.y_source, o_net_data.data);
                inj_cnt_exp++;
            end
            if (ej_n != 0 && i_pe_resp_rdy) begin
                mon_pkt = ej_q.pop_front();
                check("ej_pkt", 64'(o_pe_resp), 64'(mon_pkt));
                $display("deliver dest(%0d,%0d) src(%0d,%0d) data %h", o_pe_resp.x_dest, o_pe_resp.y_dest,
                         o_pe_resp.x_source, o_pe_resp.y_source, o_pe_resp.data);
            end
            if (i_pe_req_val && inj_n < ID) begin
                if (int'(i_pe_x_dest) >= `X_NODES || int'(i_pe_y_dest) >= `Y_NODES) begin
                    bad_exp = 1'b1;
                    $display("request dest(%0d,%0d) rejected as out of mesh", i_pe_x_dest, i_pe_y_dest);
                end else begin
                    req_model = make_pkt(int'(i_pe_x_dest), int'(i_pe_y_dest), XL, YL, int'(i_pe_data));
                    inj_q.push_back(req_model);
                end
            end
            if (i_net_data_val && ej_n < ED) begin
                ej_q.push_back(i_net_data);
                if (int'(i_net_data.x_dest) != XL || int'(i_net_data.y_dest) != YL) mis_exp = 1'b1;
                ej_cnt_exp++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_req(input int x, input int y, input int d);
        logic got;
        int   n;
        got = 1'b0;
        n   = 0;
        i_pe_req_val = 1'b1;
        i_pe_x_dest  = X_W'(x);
        i_pe_y_dest  = Y_W'(y);
        i_pe_data    = DATA_W'(d);
        while (!got && n < 50) begin
            @(negedge clk);
            got = o_pe_req_rdy;
            tick();
            n++;
        end
        i_pe_req_val = 1'b0;
        check("req_accept_timeout", got, 1'b1);
    endtask

    task automatic send_net(input packet_t p);
        int n;
        n = 0;
        while (!o_net_en && n < 50) begin
            tick();
            n++;
        end
        check("net_en_timeout", o_net_en, 1'b1);
        i_net_data_val = 1'b1;
        i_net_data     = p;
        tick();
        i_net_data_val = 1'b0;
    endtask

    task automatic check_reset_values();
        check("rst_req_rdy",  o_pe_req_rdy,   1'b1);
        check("rst_net_en",   o_net_en,       1'b1);
        check("rst_net_val",  o_net_data_val, 1'b0);
        check("rst_resp_val", o_pe_resp_val,  1'b0);
        check("rst_net_data", 64'(o_net_data), 64'd0);
        check("rst_pe_resp",  64'(o_pe_resp),  64'd0);
        check("rst_err_bad",  o_err_bad_dest, 1'b0);
        check("rst_err_mis",  o_err_misroute, 1'b0);
`ifdef NETWORK_INTERFACE_STATS_EN
        check("rst_inj_count", o_inj_count, 32'd0);
        check("rst_ej_count",  o_ej_count,  32'd0);
`endif
    endtask

    // Asynchronous reset asserted mid-cycle: outputs must collapse before the next edge.
    task automatic reset_mid_cycle();
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_values();
        inj_q.delete();
        ej_q.delete();
        bad_exp     = 1'b0;
        mis_exp     = 1'b0;
        inj_cnt_exp = '0;
        ej_cnt_exp  = '0;
        i_pe_req_val   = 1'b0;
        i_net_data_val = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        $display("reset pulse done");
    endtask

    initial begin
        int n;
        reset_n        = 1'b0;
        i_pe_req_val   = 1'b0;
        i_pe_x_dest    = '0;
        i_pe_y_dest    = '0;
        i_pe_data      = '0;
        i_net_en       = 1'b0;
        i_net_data     = '0;
        i_net_data_val = 1'b0;
        i_pe_resp_rdy  = 1'b0;
        #12;
        check_reset_values();
        tick();
        reset_n = 1'b1;
        tick();

        // Single packet to (2,3).
        i_net_en      = 1'b1;
        i_pe_resp_rdy = 1'b1;
        send_req(2, 3, 16'h00A5);
        repeat (3) tick();

        // Injection backpressure: fill, stall the fifth, then release.
        i_net_en = 1'b0;
        for (int i = 0; i < 4; i++) send_req(i % 3, i, 16'h0100 + i);
        fork
            send_req(0, 4, 16'h0104);
            begin
                repeat (3) tick();
                i_net_en = 1'b1;
            end
        join
        repeat (8) tick();

        // Ejection full, single PE pop, then drain.
        i_pe_resp_rdy = 1'b0;
        for (int i = 0; i < 4; i++) send_net(make_pkt(XL, YL, i % 3, 4 - i, 16'h0200 + i));
        repeat (2) tick();
        i_pe_resp_rdy = 1'b1;
        tick();
        i_pe_resp_rdy = 1'b0;
        repeat (2) tick();
        i_pe_resp_rdy = 1'b1;
        repeat (6) tick();

        // Error flags, then reset clears them.
        send_req(`X_NODES, 0, 16'h0BAD);
        send_net(make_pkt(0, 0, 2, 2, 16'h0300));
        repeat (4) tick();
        check("bad_dest_set", o_err_bad_dest, 1'b1);
        check("misroute_set", o_err_misroute, 1'b1);
        reset_mid_cycle();
        tick();

        // Random traffic through both FIFOs.
        for (int c = 0; c < 300; c++) begin
            i_pe_req_val  = ($urandom_range(0, 1) == 1);
            i_pe_x_dest   = X_W'($urandom_range(0, `X_NODES - 1));
            i_pe_y_dest   = Y_W'($urandom_range(0, `Y_NODES - 1));
            if ($urandom_range(0, 15) == 0) i_pe_x_dest = X_W'(`X_NODES);
            i_pe_data     = DATA_W'($urandom);
            i_net_en      = ($urandom_range(0, 9) < 7);
            i_pe_resp_rdy = ($urandom_range(0, 9) < 6);
            i_net_data_val = o_net_en && ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 7) == 0)
                i_net_data = make_pkt($urandom_range(0, `X_NODES - 1), $urandom_range(0, `Y_NODES - 1),
                                      $urandom_range(0, `X_NODES - 1), $urandom_range(0, `Y_NODES - 1), $urandom);
            else
                i_net_data = make_pkt(XL, YL, $urandom_range(0, `X_NODES - 1),
                                      $urandom_range(0, `Y_NODES - 1), $urandom);
            tick();
        end
        i_pe_req_val   = 1'b0;
        i_net_data_val = 1'b0;
        i_net_en       = 1'b1;
        i_pe_resp_rdy  = 1'b1;
        n = 0;
        while ((inj_q.size() != 0 || ej_q.size() != 0) && n < 100) begin
            tick();
            n++;
        end
        check("drain_empty", 64'(inj_q.size() + ej_q.size()), 64'd0);

        // Reset with traffic queued in both directions.
        i_net_en      = 1'b0;
        i_pe_resp_rdy = 1'b0;
        for (int i = 0; i < 3; i++) send_req(2, i, 16'h0400 + i);
        send_net(make_pkt(XL, YL, 0, 0, 16'h0500));
        send_net(make_pkt(XL, YL, 2, 4, 16'h0501));
        tick();
        reset_mid_cycle();
        i_net_en      = 1'b1;
        i_pe_resp_rdy = 1'b1;
        repeat (4) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
